design_select_ctrl: RTL and testbench
=====================================

Name: design_select_ctrl

Overview:
- Sequences a change of the active student design for the shared user-project area.
- Accepts a requested design index over a valid/ready handshake.
- Produces the per-design chip-select vector `designs_cs`, which feeds the per-design reset synchronisers directly downstream. Bit = 1 holds that design in reset; bit = 0 releases it.
- Guarantees break-before-make: every design is isolated before the I/O mux index changes, and the new design leaves reset only after a settle window.

Parameters:
- NUM_PROJECTS, 13, number of selectable designs. Indices 1..NUM_PROJECTS; index 0 = no design.
- HOLD_CYCLES, 4, cycles all designs are held isolated before the mux index changes. Must be >= 1.
- SETTLE_CYCLES, 8, cycles after the mux index change before the target design is released. Must be >= 1.
- IDX_W, $clog2(NUM_PROJECTS+1), width of index ports.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- sel_valid  input  1  request strobe; held by the source until accepted
- sel_idx  input  IDX_W  requested design index
- sel_ready  output  1  high only in IDLE; a request is accepted on a clk edge where sel_valid & sel_ready
- designs_cs  output  [NUM_PROJECTS:1]  per-design isolate; 1 = held in reset
- active_idx  output  IDX_W  I/O mux select; index of the design currently owning the pads
- busy  output  1  high in any state other than IDLE
- sel_err  output  1  one-cycle pulse when an out-of-range index is presented in IDLE

Behaviour:
- Reset (n_rst low, asynchronous):
  - state = IDLE, designs_cs = all ones, active_idx = 0, sel_err = 0, counter = 0.
  - All outputs are registered, except sel_ready and busy, which decode state.
- States: IDLE, ISOLATE, SWITCH, RELEASE.
- IDLE, request with sel_idx > NUM_PROJECTS:
  - Request is not accepted as a switch.
  - sel_err pulses for 1 cycle; state and outputs are unchanged.
  - The bench must deassert sel_valid. A held invalid request pulses sel_err every cycle.
- IDLE, valid request on edge k (index 0..NUM_PROJECTS):
  - target <= sel_idx, designs_cs <= all ones, counter <= HOLD_CYCLES-1, state <= ISOLATE.
- ISOLATE:
  - Counter decrements each edge.
  - On the edge where counter == 0, state <= SWITCH. ISOLATE lasts exactly HOLD_CYCLES cycles.
- SWITCH (1 cycle), at edge k+HOLD_CYCLES+1:
  - active_idx <= target.
  - If target == 0: state <= IDLE, designs_cs stays all ones.
  - Otherwise: counter <= SETTLE_CYCLES-1, state <= RELEASE.
- RELEASE:
  - Counter decrements each edge.
  - On the edge where counter == 0: designs_cs[target] <= 0 (all other bits remain 1), state <= IDLE.
  - This is edge k+HOLD_CYCLES+SETTLE_CYCLES+1.
- Invariants:
  - At most one bit of designs_cs is 0 at any time.
  - active_idx never changes while any designs_cs bit is 0.
- Re-selecting the current index is legal and performs a full isolate/settle cycle; this is how a single design is reset.
- sel_valid and sel_idx are ignored outside IDLE. No queueing is performed.
- Asynchronous reset mid-sequence: return immediately to the reset values. No partial release is permitted.
- Counter width: $clog2(max(HOLD_CYCLES, SETTLE_CYCLES)+1). The counter never wraps below 0.
- Downstream reset synchronisers add 2 clk of release latency. This is not accounted for in this block.

Test Plan (NUM_PROJECTS=13, HOLD_CYCLES=4, SETTLE_CYCLES=8):
- Reset then idle 5 cycles -> designs_cs = 0x3FFE (bits 13:1 all 1), active_idx = 0, sel_ready = 1, busy = 0.
- Request idx 5 accepted at edge k:
  - sel_ready = 0 from k.
  - active_idx = 5 after edge k+5.
  - designs_cs[5] = 0 after edge k+13, all other bits 1; sel_ready = 1 after k+13.
- With design 5 active, request idx 12 at edge k:
  - designs_cs[5] = 1 after edge k.
  - active_idx 5 -> 12 after k+5.
  - designs_cs[12] = 0 after k+13.
  - At most one zero bit on every cycle.
- Request idx 0 while design 3 active:
  - all designs_cs bits = 1 after edge k.
  - active_idx = 0 after k+5; IDLE after k+5, and no bit is ever released.
- Request idx 14 in IDLE -> sel_err high exactly 1 cycle, designs_cs and active_idx unchanged. Then request idx 7 while busy (edge k+2 of a prior switch) -> ignored until IDLE.
- Assert n_rst low at edge k+9 of a switch to idx 9 -> designs_cs = all ones and active_idx = 0 immediately (asynchronously). After n_rst release, IDLE with sel_ready = 1.

Source files
------------

// File: rtl/design_select_ctrl.sv
`default_nettype none
// ============================================================================
// design_select_ctrl : break-before-make sequencer for the active design select
// Revision 1.0
// ============================================================================
module design_select_ctrl #(
    parameter int NUM_PROJECTS  = 13,
    parameter int HOLD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int IDX_W         = $clog2(NUM_PROJECTS + 1)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  sel_valid,
    input  logic [IDX_W-1:0]      sel_idx,
    output logic                  sel_ready,
    output logic [NUM_PROJECTS:1] designs_cs,
    output logic [IDX_W-1:0]      active_idx,
    output logic                  busy,
    output logic                  sel_err
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_INIT   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] MAX_IDX     = IDX_W'(NUM_PROJECTS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        SWITCH  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      target, target_nxt;
    logic [CNT_W-1:0]      counter, counter_nxt;
    logic [NUM_PROJECTS:1] cs_nxt;
    logic [NUM_PROJECTS:1] release_mask;
    logic [IDX_W-1:0]      active_nxt;
    logic                  err_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            target     <= '0;
            counter    <= '0;
            designs_cs <= '1;
            active_idx <= '0;
            sel_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            counter    <= counter_nxt;
            designs_cs <= cs_nxt;
            active_idx <= active_nxt;
            sel_err    <= err_nxt;
        end
    end

    // Only the target's bit is cleared, so at most one design is ever live.
    always_comb begin
        release_mask = '1;
        for (int i = 1; i <= NUM_PROJECTS; i++) begin
            release_mask[i] = (IDX_W'(i) != target);
        end
    end

    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        counter_nxt = counter;
        cs_nxt      = designs_cs;
        active_nxt  = active_idx;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    if (sel_idx > MAX_IDX) begin
                        err_nxt = 1'b1;
                    end else begin
                        target_nxt  = sel_idx;
                        cs_nxt      = '1;
                        counter_nxt = HOLD_INIT;
                        state_nxt   = ISOLATE;
                    end
                end
            end
            ISOLATE: begin
                if (counter == '0) begin
                    state_nxt = SWITCH;
                end else begin
                    counter_nxt = counter - CNT_W'(1);
                end
            end
            SWITCH: begin
                // Pads move only while every design is isolated.
                active_nxt = target;
                if (target == '0) begin
                    state_nxt = IDLE;
                end else begin
                    counter_nxt = SETTLE_INIT;
                    state_nxt   = RELEASE;
                end
            end
            RELEASE: begin
                if (counter == '0) begin
                    cs_nxt    = release_mask;
                    state_nxt = IDLE;
                end else begin
                    counter_nxt = counter - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_design_select_ctrl.sv
`default_nettype none
// ============================================================================
// tb_design_select_ctrl : timeline-model checked bench for design_select_ctrl
// Revision 1.0
// ============================================================================
module tb_design_select_ctrl;

    localparam int N = 13;
    localparam int H = 4;
    localparam int S = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         sel_valid = 1'b0;
    logic [W-1:0] sel_idx = '0;
    logic         sel_ready;
    logic [N:1]   designs_cs;
    logic [W-1:0] active_idx;
    logic         busy;
    logic         sel_err;

    always #5 clk = ~clk;

    design_select_ctrl #(
        .NUM_PROJECTS (N),
        .HOLD_CYCLES  (H),
        .SETTLE_CYCLES(S),
        .IDX_W        (W)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx),
        .sel_ready (sel_ready),
        .designs_cs(designs_cs),
        .active_idx(active_idx),
        .busy      (busy),
        .sel_err   (sel_err)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted request is a timeline of edge numbers
    // (switch edge, done edge); outputs follow from where the edge count sits.
    int           n = 0;
    int           done_edge = -1;
    int           sw_edge = -1;
    logic [W-1:0] tgt = '0;
    logic [W-1:0] old_active = '0;
    logic [W-1:0] m_active = '0;
    logic [N:1]   m_cs = '1;
    bit           m_busy = 1'b0;
    bit           m_err = 1'b0;
    bit           rst_seen = 1'b0;

    always @(negedge n_rst) begin
        done_edge  = -1;
        sw_edge    = -1;
        tgt        = '0;
        old_active = '0;
        m_active   = '0;
        m_cs       = '1;
        m_busy     = 1'b0;
        m_err      = 1'b0;
        rst_seen   = 1'b1;
    end

    always @(posedge clk) begin
        n++;
        if (n_rst === 1'b1) begin
            m_err = 1'b0;
            if ((n > done_edge) && sel_valid) begin
                if (sel_idx > N) begin
                    m_err = 1'b1;
                end else begin
                    old_active = m_active;
                    tgt        = sel_idx;
                    sw_edge    = n + H + 1;
                    done_edge  = (tgt == 0) ? n + H + 1 : n + H + S + 1;
                end
            end
            m_busy   = (n < done_edge);
            m_active = (n >= sw_edge) ? tgt : old_active;
            m_cs     = '1;
            if (tgt != 0 && n >= done_edge) m_cs[tgt] = 1'b0;
        end
    end

    logic [N:1]   prev_cs = '1;
    logic [W-1:0] prev_active = '0;

    always @(negedge clk) begin
        chk("cs", 32'(designs_cs), 32'(m_cs));
        chk("active_idx", 32'(active_idx), 32'(m_active));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("sel_ready", 32'(sel_ready), 32'(!m_busy));
        chk("sel_err", 32'(sel_err), 32'(m_err));
        chk("one_zero_max", 32'($countones(~designs_cs) <= 1), 32'd1);
        if (!rst_seen && prev_cs != '1) begin
            chk("active_stable_while_live", 32'(active_idx), 32'(prev_active));
        end
        prev_cs     = designs_cs;
        prev_active = active_idx;
        rst_seen    = 1'b0;
    end

    task automatic go(input logic [W-1:0] idx);
        @(negedge clk);
        sel_valid = 1'b1;
        sel_idx   = idx;
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
    endtask

    task automatic edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        edges(5);
        chk("rst_cs_3FFE", 32'({designs_cs, 1'b0}), 32'h3FFE);
        chk("rst_active", 32'(active_idx), 32'd0);
        chk("rst_ready", 32'(sel_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        go(5);
        chk("sel5_ready_low", 32'(sel_ready), 32'd0);
        edges(5);
        chk("sel5_active", 32'(active_idx), 32'd5);
        chk("sel5_model_active", 32'(m_active), 32'd5);
        edges(8);
        chk("sel5_cs", 32'(designs_cs), 32'h1FEF);
        chk("sel5_model_cs", 32'(m_cs), 32'h1FEF);
        chk("sel5_ready_back", 32'(sel_ready), 32'd1);

        go(12);
        chk("sel12_cs5_iso", 32'(designs_cs[5]), 32'd1);
        edges(5);
        chk("sel12_active", 32'(active_idx), 32'd12);
        edges(8);
        chk("sel12_cs", 32'(designs_cs), 32'h17FF);

        go(3);
        edges(13);
        chk("sel3_cs", 32'(designs_cs), 32'h1FFB);
        go(0);
        chk("sel0_cs_all", 32'(designs_cs), 32'h1FFF);
        edges(5);
        chk("sel0_active", 32'(active_idx), 32'd0);
        chk("sel0_idle", 32'(busy), 32'd0);
        edges(10);
        chk("sel0_never_release", 32'(designs_cs), 32'h1FFF);

        @(negedge clk);
        sel_valid = 1'b1;
        sel_idx   = 4'd14;
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
        chk("err_pulse", 32'(sel_err), 32'd1);
        chk("err_cs", 32'(designs_cs), 32'h1FFF);
        chk("err_ready", 32'(sel_ready), 32'd1);
        edges(1);
        chk("err_one_cycle", 32'(sel_err), 32'd0);

        go(2);
        edges(1);
        sel_valid = 1'b1;
        sel_idx   = 4'd7;
        edges(4);
        chk("busy_ignore_active", 32'(active_idx), 32'd2);
        edges(8);
        chk("busy_ignore_cs2", 32'(designs_cs), 32'h1FFD);
        edges(1);
        sel_valid = 1'b0;
        chk("held_accept", 32'(busy), 32'd1);
        edges(5);
        chk("held_active7", 32'(active_idx), 32'd7);
        edges(8);

        go(9);
        edges(9);
        n_rst = 1'b0;
        #1;
        chk("async_cs", 32'(designs_cs), 32'h1FFF);
        chk("async_active", 32'(active_idx), 32'd0);
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        edges(1);
        chk("post_rst_ready", 32'(sel_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        repeat (1500) begin
            @(negedge clk);
            #1;
            sel_valid = ($urandom_range(0, 3) != 0);
            sel_idx   = W'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                n_rst = 1'b0;
                #2;
                n_rst = 1'b1;
            end
        end
        sel_valid = 1'b0;
        edges(20);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
